// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin CPU/DMA arbiter in front of a single-access SDRAM port
// One access in flight at a time; a watchdog aborts accesses whose mem_done never arrives.
module ram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_done,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic       last_dma;
  logic       grant_dma;
  logic       lat_we;
  logic       timed_out;
  logic [7:0] wait_cnt;
  logic       pick_dma;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    pick_dma = dma_req && (!cpu_req || !last_dma);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_dma  <= 1'b1;
      grant_dma <= 1'b0;
      lat_we    <= 1'b0;
      timed_out <= 1'b0;
      wait_cnt  <= 8'd0;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req || dma_req) begin
            grant_dma <= pick_dma;
            lat_we    <= pick_dma ? dma_we : cpu_we;
            mem_addr  <= pick_dma ? dma_addr : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            wait_cnt  <= 8'd0;
            timed_out <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A completion on the final watchdog cycle still wins over the abort.
          if (mem_done) begin
            if (!lat_we) begin
              if (grant_dma) dma_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
            state <= ST_DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            if (!lat_we) begin
              if (grant_dma) dma_rdata <= 8'hFF;
              else           cpu_rdata <= 8'hFF;
            end
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          last_dma  <= grant_dma;
          timed_out <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset drops them at once.
  assign mem_rd_req  = (state == ST_WAIT) && !lat_we;
  assign mem_wr_req  = (state == ST_WAIT) && lat_we;
  assign cpu_ack     = (state == ST_DONE) && !grant_dma;
  assign dma_ack     = (state == ST_DONE) && grant_dma;
  assign timeout_err = (state == ST_DONE) && timed_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk25 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic        cpu_ack, dma_ack;
  logic        mem_rd_req, mem_wr_req, mem_done, timeout_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk25(clk25), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .timeout_err(timeout_err)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    bit          cr;
    bit          cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    bit          dr;
    bit          dw;
    logic [15:0] da;
    logic [7:0]  dd;
    int          k;
    logic [7:0]  rd;
    bit          e_dma;
    int          e_ack;
    bit          e_to;
    logic [7:0]  e_crd;
    logic [7:0]  e_drd;
  } vec_t;

  vec_t tbl [10];

  bit         m_last_dma;
  logic [7:0] m_rdata [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Call at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic access(input string pre, input vec_t v);
    int         ack_cyc;
    int         req_cyc;
    bit         ack_dma, both, to_seen, bus_bad;
    logic       exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wd;
    ack_cyc = -1;
    req_cyc = 0;
    ack_dma = 0; both = 0; to_seen = 0; bus_bad = 0;
    exp_we   = v.e_dma ? v.dw : v.cw;
    exp_addr = v.e_dma ? v.da : v.ca;
    exp_wd   = v.e_dma ? v.dd : v.cd;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
    for (int c = 1; c <= TIMEOUT + 5 && ack_cyc < 0; c++) begin
      @(negedge clk25);
      mem_done = 1'b0;
      if (mem_rd_req || mem_wr_req) begin
        req_cyc++;
        if (mem_wr_req !== exp_we || mem_rd_req === mem_wr_req || mem_addr !== exp_addr ||
            (exp_we && mem_wdata !== exp_wd))
          bus_bad = 1;
      end
      if (cpu_ack || dma_ack) begin
        ack_cyc = c;
        ack_dma = dma_ack;
        both    = cpu_ack && dma_ack;
        to_seen = timeout_err;
      end
      if (c == v.k) begin
        mem_done  = 1'b1;
        mem_rdata = v.rd;
      end
    end
    @(negedge clk25);
    mem_done = 1'b0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    chk({pre, " ack_cycle"}, 32'(ack_cyc), 32'(v.e_ack));
    chk({pre, " ack_is_dma"}, 32'(ack_dma), 32'(v.e_dma));
    chk({pre, " acks_together"}, 32'(both), 32'd0);
    chk({pre, " timeout_err"}, 32'(to_seen), 32'(v.e_to));
    chk({pre, " mem_req_cycles"}, 32'(req_cyc), 32'(v.e_ack - 1));
    chk({pre, " mem_bus_bad"}, 32'(bus_bad), 32'd0);
    chk({pre, " cpu_rdata"}, 32'(cpu_rdata), 32'(v.e_crd));
    chk({pre, " dma_rdata"}, 32'(dma_rdata), 32'(v.e_drd));
    chk({pre, " idle_quiet"}, 32'({mem_rd_req, mem_wr_req, cpu_ack, dma_ack, timeout_err}), 32'd0);
  endtask

  // Transaction-level prediction: who wins, when the ack lands, what each rdata holds.
  task automatic rand_txn(input int i);
    vec_t v;
    int   sel, r;
    bit   tout, win_we;
    sel = $urandom_range(1, 3);
    r   = $urandom_range(0, 9);
    v.cr = sel[0]; v.cw = 1'($urandom_range(0, 1)); v.ca = 16'($urandom); v.cd = 8'($urandom);
    v.dr = sel[1]; v.dw = 1'($urandom_range(0, 1)); v.da = 16'($urandom); v.dd = 8'($urandom);
    v.k  = (r == 0) ? 0 : (r == 9) ? TIMEOUT : r;
    v.rd = 8'($urandom);
    if (v.cr && v.dr) v.e_dma = !m_last_dma;
    else              v.e_dma = v.dr;
    tout    = (v.k == 0) || (v.k > TIMEOUT);
    v.e_ack = tout ? TIMEOUT + 1 : v.k + 1;
    v.e_to  = tout;
    win_we  = v.e_dma ? v.dw : v.cw;
    if (!win_we) m_rdata[v.e_dma] = tout ? 8'hFF : v.rd;
    v.e_crd = m_rdata[0];
    v.e_drd = m_rdata[1];
    m_last_dma = v.e_dma;
    access($sformatf("rnd%0d", i), v);
  endtask

  initial begin
    int acks;
    bit stray_bus;
    vec_t v;

    //        cr cw ca        cd     dr dw da        dd     k   rd     dma ack to crd    drd
    tbl[0] = '{1, 0, 16'h0300, 8'h00, 0, 0, 16'h0000, 8'h00, 2,  8'hA5, 0, 3,  0, 8'hA5, 8'h00};
    tbl[1] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, 1,  8'h5A, 1, 2,  0, 8'hA5, 8'h5A};
    tbl[2] = '{1, 1, 16'h0010, 8'h11, 1, 1, 16'h2000, 8'h22, 3,  8'h00, 0, 4,  0, 8'hA5, 8'h5A};
    tbl[3] = '{1, 0, 16'h0020, 8'h00, 1, 0, 16'h2020, 8'h00, 2,  8'h6B, 1, 3,  0, 8'hA5, 8'h6B};
    tbl[4] = '{1, 1, 16'h0040, 8'h33, 1, 1, 16'h2040, 8'h55, 1,  8'h00, 0, 2,  0, 8'hA5, 8'h6B};
    tbl[5] = '{1, 0, 16'h0030, 8'h00, 1, 1, 16'h2030, 8'h44, 2,  8'hC7, 1, 3,  0, 8'hA5, 8'h6B};
    tbl[6] = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'hE000, 8'h3C, 0,  8'h00, 1, 65, 1, 8'hA5, 8'h6B};
    tbl[7] = '{1, 0, 16'h4000, 8'h00, 0, 0, 16'h0000, 8'h00, 64, 8'h7E, 0, 65, 0, 8'h7E, 8'h6B};
    tbl[8] = '{1, 0, 16'h5555, 8'h00, 0, 0, 16'h0000, 8'h00, 0,  8'h00, 0, 65, 1, 8'hFF, 8'h6B};
    tbl[9] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h6666, 8'h00, 0,  8'h00, 1, 65, 1, 8'hFF, 8'hFF};

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_done = 0; mem_rdata = 0;
    repeat (2) @(negedge clk25);
    chk("reset cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("reset dma_rdata", 32'(dma_rdata), 32'h00);
    chk("reset mem_addr", 32'(mem_addr), 32'h0000);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h00);
    chk("reset strobes", 32'({mem_rd_req, mem_wr_req, cpu_ack, dma_ack, timeout_err}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) access($sformatf("vec%0d", i), tbl[i]);

    m_last_dma = 1'b1;
    m_rdata[0] = 8'hFF;
    m_rdata[1] = 8'hFF;
    for (int i = 0; i < 40; i++) rand_txn(i);

    // Reset in the middle of a read: request drops without waiting for a clock edge.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0ABC;
    @(negedge clk25);
    chk("rst_mid mem_rd_req before", 32'(mem_rd_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid mem_rd_req async", 32'(mem_rd_req), 32'd0);
    chk("rst_mid mem_addr", 32'(mem_addr), 32'h0000);
    acks = 0;
    repeat (3) begin
      @(negedge clk25);
      acks += int'(cpu_ack) + int'(dma_ack) + int'(timeout_err);
    end
    chk("rst_mid no ack", 32'(acks), 32'd0);
    cpu_req = 0;
    rst = 1'b0;
    v = '{1, 0, 16'h0301, 8'h00, 0, 0, 16'h0000, 8'h00, 2, 8'hC3, 0, 3, 0, 8'hC3, 8'h00};
    access("after_rst", v);

    // Requester lets go after grant; stray completions land in DONE and IDLE.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0777;
    acks = 0;
    stray_bus = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk25);
      mem_done = 1'b0;
      if (c == 1) begin
        chk("drop mem_rd_req", 32'(mem_rd_req), 32'd1);
        cpu_req = 1'b0;
      end
      if (c == 3) begin mem_done = 1'b1; mem_rdata = 8'h99; end
      if (c == 4) begin
        chk("drop cpu_ack", 32'(cpu_ack), 32'd1);
        mem_done = 1'b1; mem_rdata = 8'h22;
      end
      if (c == 5) begin mem_done = 1'b1; mem_rdata = 8'h11; end
      if (c >= 5 && (mem_rd_req || mem_wr_req || timeout_err)) stray_bus = 1;
      acks += int'(cpu_ack) + int'(dma_ack);
    end
    mem_done = 1'b0;
    chk("drop ack count", 32'(acks), 32'd1);
    chk("drop cpu_rdata", 32'(cpu_rdata), 32'h99);
    chk("stray no activity", 32'(stray_bus), 32'd0);
    v = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0888, 8'h00, 1, 8'h44, 1, 2, 0, 8'h99, 8'h44};
    access("after_stray", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum clk25 cycles spent waiting for mem_done before aborting; legal range 2..255.
REQ-002 clk25  input  1  system clock, 25 MHz.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU write (1) / read (0).
REQ-006 cpu_addr  input  16  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  CPU read data.
REQ-009 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-010 dma_req, dma_we, dma_addr[15:0], dma_wdata[7:0]  input  1/1/16/8  DMA (serial loader) request set, same semantics as the CPU set.
REQ-011 dma_rdata  output  8  DMA read data.
REQ-012 dma_ack  output  1  one-cycle DMA completion pulse.
REQ-013 mem_rd_req, mem_wr_req  output  1  read/write request to the SDRAM controller.
REQ-014 mem_addr  output  16  memory address.
REQ-015 mem_wdata  output  8  memory write data.
REQ-016 mem_rdata  input  8  memory read data, valid when mem_done=1.
REQ-017 mem_done  input  1  one-cycle memory completion pulse.
REQ-018 timeout_err  output  1  one-cycle pulse on aborted access.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-020 In IDLE, with exactly one req high, the FSM SHALL grant that requester, latch its we/addr/wdata, and move to WAIT on the next edge.
REQ-021 In IDLE, with both req high, the FSM SHALL grant the requester not granted last (round-robin); last_grant resets to DMA, so the CPU wins the first tie.
REQ-022 In WAIT, exactly one of mem_rd_req/mem_wr_req (per latched we) SHALL be high, and mem_addr/mem_wdata SHALL hold the latched values; otherwise both requests SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-023 In WAIT, mem_done=1 SHALL capture mem_rdata for reads into the granted requester's rdata register and move to DONE.
REQ-024 A 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES-1 without mem_done, the FSM SHALL move to DONE, load 8'hFF into the granted rdata register (reads only), and pulse timeout_err in the DONE cycle.
REQ-025 mem_done arriving on the same cycle the counter expires SHALL count as success: no timeout_err, real data captured.
REQ-026 In DONE, the granted requester's ack SHALL be 1 for exactly that cycle; the FSM SHALL return to IDLE on the next edge and update last_grant.
REQ-027 Latency: req sampled in IDLE on cycle 0 -> mem request high on cycle 1 -> mem_done on cycle k (k>=1) -> ack on cycle k+1 -> next grant possible on cycle k+2.
REQ-028 cpu_rdata/dma_rdata SHALL hold their last captured value until the next completed read for that requester; write completions SHALL not alter them.
REQ-029 A requester deasserting req after grant SHALL not abort the access; the access completes and ack is still pulsed.
REQ-030 mem_done received in IDLE or DONE SHALL be ignored.
REQ-031 cpu_ack and dma_ack SHALL never be high together; at most one mem request SHALL be outstanding.

Reset
REQ-032 On rst: state IDLE, last_grant=DMA, wait counter 0, cpu_rdata=dma_rdata=8'h00, mem_addr=16'h0000, mem_wdata=8'h00, all request/ack/timeout_err outputs 0.
REQ-033 rst asserted mid-access SHALL abandon the access immediately with no ack and no timeout_err; after release, the FSM SHALL accept a new request on the first IDLE cycle.

Verification
REQ-034 CPU read of 16'h0300, mem_done one cycle after mem_rd_req with mem_rdata=8'hA5 -> cpu_ack at cycle 3, cpu_rdata=8'hA5, dma_ack=0.
REQ-035 cpu_req and dma_req both held for four accesses -> grant order CPU, DMA, CPU, DMA; acks alternate; mem_addr matches each grant.
REQ-036 DMA write 16'hE000=8'h3C, mem_done never asserted -> mem_wr_req high for 64 cycles, then dma_ack and timeout_err pulse together, dma_rdata unchanged.
REQ-037 CPU read where mem_done coincides with the counter's last cycle -> cpu_rdata=mem_rdata, timeout_err=0.
REQ-038 rst pulsed during WAIT -> mem_rd_req drops asynchronously, no ack; a subsequent CPU read completes normally.
REQ-039 cpu_req dropped one cycle after grant; stray mem_done injected in IDLE -> access still acked once, stray pulse produces no ack and no state change.
